// File: rtl/pi_dma_pkg.sv
// pi_dma_pkg: shared state encoding, default strobe length and datapath widths for the PI DMA sequencer
package pi_dma_pkg;
  localparam int MEM_WAIT_DEF = 2;
  localparam int ADDR_W = 24;
  localparam int LEN_W = 16;
  localparam int WAIT_W = 4;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_STROBE, S_DELIVER, S_NEXT, S_FINISH} state_t;
endpackage

// File: rtl/pi_dma_strobe.sv
// pi_dma_strobe: strobe-length down-counter that flags the final cycle of a memory strobe
module pi_dma_strobe
  import pi_dma_pkg::*;
#(
  parameter int MEM_WAIT = MEM_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic last
);
  logic [WAIT_W-1:0] cnt;
  // reload on strobe entry, then count down to zero while the strobe runs
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= WAIT_W'(MEM_WAIT - 1);
    else if (run && cnt != '0) cnt <= cnt - 1'b1;
  assign last = run && cnt == '0;
endmodule

// File: rtl/pi_dma_seq.sv
// pi_dma_seq: byte-serial PI memory DMA sequencer; running checksum enabled by PI_DMA_SUM_EN
module pi_dma_seq
  import pi_dma_pkg::*;
#(
  parameter int MEM_WAIT = MEM_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic              cmd_rd,
  input  logic              cmd_mem,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] pi_addr,
  output logic [7:0]        pi_do,
  input  logic [7:0]        pi_din,
  output logic              pi_oe,
  output logic              pi_we_hi,
  output logic              pi_we_lo,
  output logic              pi_busy,
  output logic              pi_dst_mem,
  output logic              done,
  output logic [15:0]       sum
);
  state_t state, state_n;
  logic rd_q, mem_q, last, load, run;
  logic [LEN_W-1:0] rem;
  logic start_ok;
  assign start_ok = state == S_IDLE && cmd_start;
  assign run = state == S_STROBE;
  assign load = state_n == S_STROBE && state != S_STROBE;
  pi_dma_strobe #(.MEM_WAIT(MEM_WAIT)) u_strobe (
    .clk (clk),
    .rst (rst),
    .load(load),
    .run (run),
    .last(last)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  // next-state decode
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (cmd_start) state_n = cmd_len == '0 ? S_FINISH : cmd_rd ? S_STROBE : S_FETCH;
      S_FETCH:   if (wr_valid) state_n = S_STROBE;
      S_STROBE:  if (last) state_n = rd_q ? S_DELIVER : S_NEXT;
      S_DELIVER: if (rd_ready) state_n = S_NEXT;
      S_NEXT:    state_n = rem == LEN_W'(1) ? S_FINISH : rd_q ? S_STROBE : S_FETCH;
      S_FINISH:  state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end
  // command latch, byte registers, address and remaining-count stepping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_q    <= 1'b0;
      mem_q   <= 1'b0;
      rem     <= '0;
      pi_addr <= '0;
      pi_do   <= '0;
      rd_data <= '0;
    end else begin
      if (start_ok) begin
        rd_q    <= cmd_rd;
        mem_q   <= cmd_mem;
        pi_addr <= cmd_addr;
        rem     <= cmd_len;
      end
      if (state == S_FETCH && wr_valid) pi_do <= wr_data;
      if (run && rd_q && last) rd_data <= pi_din;
      if (state == S_NEXT) begin
        pi_addr <= pi_addr + 1'b1;
        rem     <= rem - 1'b1;
      end
    end
`ifdef PI_DMA_SUM_EN
  // checksum of moved bytes, cleared by each accepted command
  always_ff @(posedge clk or posedge rst)
    if (rst) sum <= '0;
    else if (start_ok) sum <= '0;
    else if (state == S_NEXT) sum <= sum + {8'd0, rd_q ? rd_data : pi_do};
`else
  assign sum = '0;
`endif
  assign wr_ready   = state == S_FETCH;
  assign rd_valid   = state == S_DELIVER;
  assign pi_oe      = run && rd_q;
  assign pi_we_hi   = run && !rd_q && !pi_addr[0];
  assign pi_we_lo   = run && !rd_q && pi_addr[0];
  assign pi_busy    = state != S_IDLE;
  assign pi_dst_mem = pi_busy && mem_q;
  assign done       = state == S_FINISH;
endmodule

// File: tb/tb_pi_dma_seq.sv
// tb_pi_dma_seq: per-cycle schedule model of the DMA sequencer with directed transfers and literal spot checks
module tb_pi_dma_seq;
  localparam int MW = 2;
  localparam int P = MW + 2;
  localparam int NC = 115;
`ifdef PI_DMA_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif
  logic clk = 1'b0, rst;
  logic cmd_start, cmd_rd, cmd_mem, wr_valid, wr_ready, rd_valid, rd_ready;
  logic [23:0] cmd_addr, pi_addr;
  logic [15:0] cmd_len, sum;
  logic [7:0] wr_data, rd_data, pi_do, pi_din;
  logic pi_oe, pi_we_hi, pi_we_lo, pi_busy, pi_dst_mem, done;
  pi_dma_seq #(.MEM_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_rd(cmd_rd), .cmd_mem(cmd_mem),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .pi_addr(pi_addr), .pi_do(pi_do), .pi_din(pi_din), .pi_oe(pi_oe), .pi_we_hi(pi_we_hi),
    .pi_we_lo(pi_we_lo), .pi_busy(pi_busy), .pi_dst_mem(pi_dst_mem), .done(done), .sum(sum)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a == 24'h5 ? 8'h5A : a == 24'h6 ? 8'hA5 : a[7:0] ^ 8'hC3;
  endfunction
  assign pi_din = mem_byte(pi_addr);
  logic rst_a[NC], st_a[NC], rd_a[NC], mem_a[NC], rr_a[NC];
  logic [23:0] addr_a[NC], x_addr[NC];
  logic [15:0] len_a[NC], e_sum[NC];
  logic [7:0] wd_a[NC], x_do[NC], x_rdd[NC];
  logic e_busy[NC], e_hi[NC], e_lo[NC], e_oe[NC], e_done[NC], e_wrr[NC], e_rdv[NC], e_mem[NC];
  logic ck_addr[NC], ck_do[NC], ck_rdd[NC];
  int cyc, checks, failures, busy_len0, oe_rd;
  bit run;
  int done_log[$];
  logic [7:0] snap_rdd35, snap_rdd40;
  logic snap_rdv35, snap_hi61, snap_lo61;
  logic [23:0] snap_addr61;
  logic [15:0] snap_sum25;
  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, exp);
    end
  endtask
  task automatic set_busy(input int a, input int b, input logic m);
    for (int x = a; x <= b; x++) begin
      e_busy[x] = 1'b1;
      e_mem[x] = m;
    end
  endtask
  task automatic set_sum(input int from, input logic [15:0] s);
    for (int x = from; x < NC; x++) e_sum[x] = SUM_EN ? s : 16'h0;
  endtask
  task automatic plan_cmd(input int c0, input logic r, input logic [23:0] a, input int n, input logic m);
    st_a[c0] = 1'b1;
    rd_a[c0] = r;
    mem_a[c0] = m;
    addr_a[c0] = a;
    len_a[c0] = 16'(n);
    set_sum(c0 + 1, 16'h0);
  endtask
  task automatic plan_write(input int c0, input logic [23:0] a, input int n, input logic m, input logic [7:0] base);
    int b, f;
    logic [23:0] ai;
    logic [7:0] by;
    logic [15:0] s;
    s = 16'h0;
    plan_cmd(c0, 1'b0, a, n, m);
    for (int i = 0; i < n; i++) begin
      b = c0 + 1 + i * P;
      ai = a + 24'(i);
      by = base + 8'(i * 17);
      set_busy(b, b + P - 1, m);
      e_wrr[b] = 1'b1;
      wd_a[b] = by;
      for (int k = 1; k <= MW; k++) begin
        e_hi[b + k] = !ai[0];
        e_lo[b + k] = ai[0];
        ck_addr[b + k] = 1'b1;
        x_addr[b + k] = ai;
        ck_do[b + k] = 1'b1;
        x_do[b + k] = by;
      end
      s = s + {8'h0, by};
      set_sum(b + P, s);
    end
    f = c0 + 1 + n * P;
    set_busy(f, f, m);
    e_done[f] = 1'b1;
  endtask
  task automatic plan_read(input int c0, input logic [23:0] a, input int n, input logic m, input logic [11:0] dl);
    int s, d;
    logic [23:0] ai;
    logic [15:0] sm;
    sm = 16'h0;
    s = c0 + 1;
    plan_cmd(c0, 1'b1, a, n, m);
    for (int i = 0; i < n; i++) begin
      ai = a + 24'(i);
      d = int'(dl[4*i +: 4]);
      set_busy(s, s + MW + d + 1, m);
      for (int k = 0; k < MW; k++) begin
        e_oe[s + k] = 1'b1;
        ck_addr[s + k] = 1'b1;
        x_addr[s + k] = ai;
      end
      for (int k = 0; k <= d; k++) begin
        e_rdv[s + MW + k] = 1'b1;
        ck_rdd[s + MW + k] = 1'b1;
        x_rdd[s + MW + k] = mem_byte(ai);
        rr_a[s + MW + k] = k == d;
      end
      sm = sm + {8'h0, mem_byte(ai)};
      set_sum(s + MW + d + 2, sm);
      s = s + MW + d + 2;
    end
    set_busy(s, s, m);
    e_done[s] = 1'b1;
  endtask
  task automatic plan_reset(input int c, input int k);
    for (int x = c; x < NC; x++) begin
      e_busy[x] = 0; e_hi[x] = 0; e_lo[x] = 0; e_oe[x] = 0; e_done[x] = 0;
      e_wrr[x] = 0; e_rdv[x] = 0; e_mem[x] = 0; e_sum[x] = 0;
      ck_addr[x] = 0; ck_do[x] = 0; ck_rdd[x] = 0;
    end
    for (int x = c; x < c + k; x++) begin
      rst_a[x] = 1'b1;
      ck_addr[x] = 1'b1; x_addr[x] = 24'h0;
      ck_do[x] = 1'b1; x_do[x] = 8'h0;
      ck_rdd[x] = 1'b1; x_rdd[x] = 8'h0;
    end
  endtask
  task automatic extra_start(input int c);
    st_a[c] = 1'b1;
    rd_a[c] = 1'b0;
    mem_a[c] = 1'b1;
    addr_a[c] = 24'h000777;
    len_a[c] = 16'd5;
  endtask
  always @(negedge clk) if (run) begin
    chk("ctl", cyc, 32'({pi_busy, pi_we_hi, pi_we_lo, pi_oe, done, wr_ready, rd_valid, pi_dst_mem}),
        32'({e_busy[cyc], e_hi[cyc], e_lo[cyc], e_oe[cyc], e_done[cyc], e_wrr[cyc], e_rdv[cyc], e_mem[cyc]}));
    if (ck_addr[cyc]) chk("pi_addr", cyc, 32'(pi_addr), 32'(x_addr[cyc]));
    if (ck_do[cyc]) chk("pi_do", cyc, 32'(pi_do), 32'(x_do[cyc]));
    if (ck_rdd[cyc]) chk("rd_data", cyc, 32'(rd_data), 32'(x_rdd[cyc]));
    chk("sum", cyc, 32'(sum), 32'(e_sum[cyc]));
    if (done) done_log.push_back(cyc);
    if (pi_busy && cyc >= 50 && cyc < 55) busy_len0++;
    if (pi_oe && cyc >= 30 && cyc < 46) oe_rd++;
    if (cyc == 25) snap_sum25 = sum;
    if (cyc == 35) begin snap_rdd35 = rd_data; snap_rdv35 = rd_valid; end
    if (cyc == 40) snap_rdd40 = rd_data;
    if (cyc == 61) begin snap_hi61 = pi_we_hi; snap_lo61 = pi_we_lo; snap_addr61 = pi_addr; end
  end
  initial begin
    int exp_done[6];
    exp_done = '{22, 42, 51, 64, 85, 104};
    for (int x = 0; x < NC; x++) begin
      rst_a[x] = 0; st_a[x] = 0; rd_a[x] = 0; mem_a[x] = 0; rr_a[x] = 1; addr_a[x] = 0; len_a[x] = 0;
      wd_a[x] = 8'hEE; x_addr[x] = 0; x_do[x] = 0; x_rdd[x] = 0;
    end
    plan_reset(0, 3);
    plan_write(5, 24'h000100, 4, 1'b1, 8'h11);
    plan_read(30, 24'h000005, 2, 1'b1, 12'h003);
    plan_write(50, 24'h000ABC, 0, 1'b1, 8'h00);
    plan_write(55, 24'hFFFFFF, 2, 1'b0, 8'h5E);
    plan_write(70, 24'h000200, 8, 1'b1, 8'h01);
    plan_reset(76, 2);
    plan_write(80, 24'h000300, 1, 1'b1, 8'h7F);
    plan_read(90, 24'h000040, 3, 1'b0, 12'h010);
    extra_start(93);
    extra_start(100);
    extra_start(104);
    checks = 0; failures = 0; busy_len0 = 0; oe_rd = 0;
    wr_valid = 1'b1;
    run = 1'b1;
    for (int c = 0; c < NC; c++) begin
      cyc = c;
      rst = rst_a[c];
      cmd_start = st_a[c];
      cmd_rd = rd_a[c];
      cmd_mem = mem_a[c];
      cmd_addr = addr_a[c];
      cmd_len = len_a[c];
      wr_data = wd_a[c];
      rd_ready = rr_a[c];
      @(posedge clk);
      #1;
    end
    run = 1'b0;
    chk("done_count", 0, 32'(done_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < done_log.size()) chk("done_cycle", i, 32'(done_log[i]), 32'(exp_done[i]));
    chk("len0_busy_cycles", 50, 32'(busy_len0), 32'd1);
    chk("read_oe_cycles", 30, 32'(oe_rd), 32'd4);
    chk("sum_after_write", 25, 32'(snap_sum25), SUM_EN ? 32'h00AA : 32'h0);
    chk("stall_rd_data", 35, 32'({snap_rdv35, snap_rdd35}), 32'h15A);
    chk("second_rd_data", 40, 32'(snap_rdd40), 32'hA5);
    chk("wrap_strobe", 61, 32'({snap_hi61, snap_lo61, snap_addr61}), 32'h2000000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
